// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory controller
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          WAIT_W    = 4;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - single-port word RAM with byte enables and registered read
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // One access per enabled edge: commit enabled bytes, register the pre-write word
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - fetch-side instruction memory controller with wait states
module instr_mem_ctrl #(
    parameter int ADDRESS     = 32,
    parameter int INSTRUCTION = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   request,
    input  logic                   we_re,
    input  logic [3:0]             mask,
    input  logic [ADDRESS-1:0]     address_in,
    input  logic [INSTRUCTION-1:0] wdata,
    output logic                   ready,
    output logic                   valid,
    output logic [INSTRUCTION-1:0] instruction_fetch,
    output logic                   addr_err
);

    import imem_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_t              state_q, state_d;
    logic [WAIT_W-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]            addr_q;
    logic                     we_q;
    logic [3:0]               mask_q;
    logic [INSTRUCTION-1:0]   wdata_q;
    logic                     err_q;
    logic [INSTRUCTION-1:0]   data_q;

    logic                     accept;
    logic                     err_in;
    logic                     use_latched;
    logic                     ram_en;
    logic                     ram_write;
    logic [3:0]               ram_be;
    logic [AW-1:0]            ram_addr;
    logic [INSTRUCTION-1:0]   ram_wdata;
    logic [INSTRUCTION-1:0]   ram_rdata;
    logic [INSTRUCTION-1:0]   resp_data;

    assign ready  = (state_q != WAIT);
    assign valid  = (state_q == RESP);
    assign accept = request && ready;

    // Misaligned, or any address bit above the array span set
    assign err_in = (address_in[1:0] != 2'b00) || (address_in[ADDRESS-1:AW+2] != '0);

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_W'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields at accept so they survive the wait states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            mask_q  <= 4'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= address_in[AW+1:2];
            we_q    <= we_re;
            mask_q  <= mask;
            wdata_q <= wdata;
            err_q   <= err_in;
        end
    end

    // The array is touched only on the edge entering RESP; from WAIT the latched
    // fields drive it, with zero wait states the live request does. Holding rst
    // low blocks the access so an interrupted write can never land.
    always_comb begin
        use_latched = (state_q == WAIT);
        ram_en      = rst && (state_d == RESP);
        ram_addr    = use_latched ? addr_q  : address_in[AW+1:2];
        ram_wdata   = use_latched ? wdata_q : wdata;
        ram_write   = use_latched ? (we_q && !err_q) : (we_re && !err_in);
        ram_be      = 4'b0;
        if (ram_write) begin
            ram_be = use_latched ? mask_q : mask;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Response word for the transaction currently in RESP
    always_comb begin
        resp_data = ram_rdata;
        if (err_q) begin
            resp_data = NOP_INSTR;
        end else if (we_q) begin
            resp_data = '0;
        end
    end

    // Hold the last response so the output is stable between pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= NOP_INSTR;
        end else if (valid) begin
            data_q <= resp_data;
        end
    end

    assign instruction_fetch = valid ? resp_data : data_q;
    assign addr_err          = valid && err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - directed self-checking bench for instr_mem_ctrl
module tb_instr_mem_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    int          sel;
    logic        all_sel;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;

    logic        req0, req1, req2;
    logic        rdy  [3];
    logic        vld  [3];
    logic        aerr [3];
    logic [31:0] dat  [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign req0 = req && (all_sel || sel == 0);
    assign req1 = req && (all_sel || sel == 1);
    assign req2 = req && (all_sel || sel == 2);

    instr_mem_ctrl #(.ADDRESS(32), .INSTRUCTION(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .request(req0), .we_re(we), .mask(mask), .address_in(addr),
        .wdata(wdata), .ready(rdy[0]), .valid(vld[0]), .instruction_fetch(dat[0]), .addr_err(aerr[0]));

    instr_mem_ctrl #(.ADDRESS(32), .INSTRUCTION(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .request(req1), .we_re(we), .mask(mask), .address_in(addr),
        .wdata(wdata), .ready(rdy[1]), .valid(vld[1]), .instruction_fetch(dat[1]), .addr_err(aerr[1]));

    instr_mem_ctrl #(.ADDRESS(32), .INSTRUCTION(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .request(req2), .we_re(we), .mask(mask), .address_in(addr),
        .wdata(wdata), .ready(rdy[2]), .valid(vld[2]), .instruction_fetch(dat[2]), .addr_err(aerr[2]));

    // Drive one transaction to the selected controller; returns the response and latency
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        we = w; addr = a; mask = m; wdata = d; req = 1'b1;
        n = 0;
        while (!rdy[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (vld[sel]) break;
        end
        if (!vld[sel]) begin
            fails++;
            $display("FAIL txn_timeout: addr %h got no valid, required valid within 40 cycles", a);
            lat = -1;
        end
        rd = dat[sel];
        e  = aerr[sel];
    endtask

    task automatic test_reset();
        rst = 1'b0; all_sel = 1'b1; sel = 1; req = 1'b0;
        we = 1'b1; addr = 32'h0; mask = 4'hF; wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = i[0];
            for (int k = 0; k < 3; k++) begin
                tests++; if (vld[k] !== 1'b0) begin fails++; $display("FAIL reset_valid dut%0d: got %b required 0", k, vld[k]); end
                tests++; if (rdy[k] !== 1'b1) begin fails++; $display("FAIL reset_ready dut%0d: got %b required 1", k, rdy[k]); end
                tests++; if (dat[k] !== NOP) begin fails++; $display("FAIL reset_data dut%0d: got %h required %h", k, dat[k], NOP); end
                tests++; if (aerr[k] !== 1'b0) begin fails++; $display("FAIL reset_err dut%0d: got %b required 0", k, aerr[k]); end
            end
        end
        req = 1'b0; all_sel = 1'b0;
        // Release and request in the same cycle: the very next edge must accept
        @(negedge clk);
        rst = 1'b1; sel = 1; we = 1'b1; addr = 32'h0; mask = 4'hF; wdata = 32'h00500093; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        tests++; if (rdy[1] !== 1'b0) begin fails++; $display("FAIL first_accept_ready: got %b required 0", rdy[1]); end
        @(negedge clk);
        @(negedge clk);
        tests++; if (vld[1] !== 1'b1) begin fails++; $display("FAIL first_accept_valid: got %b required 1", vld[1]); end
        tests++; if (dat[1] !== 32'h0) begin fails++; $display("FAIL first_accept_wdata: got %h required 0", dat[1]); end
    endtask

    task automatic test_read_latency();
        sel = 1;
        @(negedge clk);
        we = 1'b0; addr = 32'h0; mask = 4'h0; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                tests++; if (rdy[1] !== 1'b0) begin fails++; $display("FAIL lat_ready t+%0d: got %b required 0", c, rdy[1]); end
            end
            tests++; if (vld[1] !== (c == 3)) begin fails++; $display("FAIL lat_valid t+%0d: got %b required %b", c, vld[1], (c == 3)); end
            if (c >= 3) begin
                tests++; if (dat[1] !== 32'h00500093) begin fails++; $display("FAIL lat_data t+%0d: got %h required 00500093", c, dat[1]); end
            end
        end
    endtask

    task automatic test_masked_write();
        logic [31:0] rd; logic e; int lat;
        sel = 1;
        txn(1'b1, 32'h4, 4'hF, 32'h11223344, rd, e, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL mw_write_latency: got %0d required 3", lat); end
        txn(1'b1, 32'h4, 4'b0011, 32'hDEADBEEF, rd, e, lat);
        tests++; if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL mw_write_resp: got %h/%b required 0/0", rd, e); end
        txn(1'b0, 32'h4, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h1122BEEF) begin fails++; $display("FAIL mw_readback: got %h required 1122beef", rd); end
        txn(1'b1, 32'h4, 4'b0000, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL mw_mask0_resp: got %h/%b required 0/0", rd, e); end
        txn(1'b0, 32'h4, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h1122BEEF) begin fails++; $display("FAIL mw_mask0_readback: got %h required 1122beef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        sel = 1;
        txn(1'b1, 32'h8, 4'hF, 32'hCAFEF00D, rd, e, lat);
        txn(1'b1, 32'hFFC, 4'hF, 32'h12345678, rd, e, lat);
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL err_lastword_write: got err %b required 0", e); end
        txn(1'b0, 32'hFFC, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h12345678 || e !== 1'b0) begin fails++; $display("FAIL err_lastword_read: got %h/%b required 12345678/0", rd, e); end
        txn(1'b0, 32'h2, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== NOP || e !== 1'b1) begin fails++; $display("FAIL err_misaligned_read: got %h/%b required 00000013/1", rd, e); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL err_latency: got %0d required 3", lat); end
        txn(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, rd, e, lat);
        tests++; if (rd !== NOP || e !== 1'b1) begin fails++; $display("FAIL err_range_write: got %h/%b required 00000013/1", rd, e); end
        txn(1'b0, 32'h1000, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== NOP || e !== 1'b1) begin fails++; $display("FAIL err_range_read: got %h/%b required 00000013/1", rd, e); end
        txn(1'b1, 32'h6, 4'hF, 32'h0, rd, e, lat);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL err_misaligned_write: got err %b required 1", e); end
        txn(1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h00500093 || e !== 1'b0) begin fails++; $display("FAIL err_word0_kept: got %h/%b required 00500093/0", rd, e); end
        txn(1'b0, 32'h4, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h1122BEEF) begin fails++; $display("FAIL err_word1_kept: got %h required 1122beef", rd); end
        txn(1'b0, 32'h8, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL err_word2_kept: got %h required cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA0A0_0000; exp_d[1] = 32'hA4A4_0004; exp_d[2] = 32'hA8A8_0008;
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 32'(4 * i), 4'hF, exp_d[i], rd, e, lat);
            tests++; if (lat !== 1) begin fails++; $display("FAIL b2b_preload_latency %0d: got %0d required 1", i, lat); end
        end
        @(negedge clk);
        we = 1'b0; mask = 4'h0; addr = 32'h0; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) addr = 32'(4 * (i + 1));
            else req = 1'b0;
            @(negedge clk);
            tests++; if (vld[0] !== 1'b1 || dat[0] !== exp_d[i]) begin fails++; $display("FAIL b2b_resp %0d: got %b/%h required 1/%h", i, vld[0], dat[0], exp_d[i]); end
        end
        @(negedge clk);
        tests++; if (vld[0] !== 1'b0 || dat[0] !== exp_d[2]) begin fails++; $display("FAIL b2b_end: got %b/%h required 0/%h", vld[0], dat[0], exp_d[2]); end
        // Write then read of the same word on consecutive edges
        we = 1'b1; addr = 32'hC; mask = 4'hF; wdata = 32'h0000_0055; req = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
        tests++; if (vld[0] !== 1'b1 || dat[0] !== 32'h0) begin fails++; $display("FAIL raw_write_resp: got %b/%h required 1/0", vld[0], dat[0]); end
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        tests++; if (vld[0] !== 1'b1 || dat[0] !== 32'h55) begin fails++; $display("FAIL raw_read_resp: got %b/%h required 1/55", vld[0], dat[0]); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic e; int lat;
        sel = 2;
        txn(1'b1, 32'h8, 4'hF, 32'h0BADF00D, rd, e, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL rmw_preload_latency: got %0d required 4", lat); end
        @(negedge clk);
        we = 1'b1; addr = 32'h8; mask = 4'hF; wdata = 32'hFFFF_FFFF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        tests++; if (rdy[2] !== 1'b0) begin fails++; $display("FAIL rmw_in_wait: got ready %b required 0", rdy[2]); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) rst = 1'b1;
            tests++; if (vld[2] !== 1'b0 || rdy[2] !== 1'b1) begin fails++; $display("FAIL rmw_idle %0d: got valid %b ready %b required 0/1", i, vld[2], rdy[2]); end
        end
        txn(1'b0, 32'h8, 4'h0, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h0BADF00D || e !== 1'b0) begin fails++; $display("FAIL rmw_word2_kept: got %h/%b required 0badf00d/0", rd, e); end
    endtask

    initial begin
        req = 1'b0; all_sel = 1'b0; sel = 1; rst = 1'b0;
        we = 1'b0; addr = '0; mask = '0; wdata = '0;
        test_reset();
        test_read_latency();
        test_masked_write();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
